note_highway: RTL and testbench
===============================

// Module: note_highway
// PURPOSE
//  Parametrised falling-note playfield for the rhythm game. Holds a ROWS-deep x LANES-wide
//  note shift register and scrolls it smoothly, one pixel step per tick, toward a judge line.
//  Judges key presses as hits, counts notes that scroll off as misses, and renders the
//  playfield pixel colour for the raster scanner. Sits between the note ROM/clock dividers
//  and the VGA adapter, replacing the fixed 4-lane logic.
// PARAMETERS
//  LANES          4    number of note lanes (1..8)
//  ROWS           11   note rows on screen; row r top = r*ROW_PITCH + sub*STEP
//  ROW_PITCH      20   pixels between rows
//  TICKS_PER_ROW  5    ticks per row advance; STEP = ROW_PITCH/TICKS_PER_ROW (must divide exactly)
//  NOTE_H         10   note height in pixels (drawn top..top+NOTE_H inclusive)
//  LANE_W         16   lane width in pixels
//  GAP            2    black separator width in pixels
//  X0             125  x of lane 0 left pixel
//  JUDGE_Y        220  judge line y (lines JUDGE_Y and JUDGE_Y+1 are drawn black)
// PORTS
//  clk         in   1        system clock
//  resetn      in   1        synchronous active-low reset
//  tick        in   1        one-cycle scroll strobe (50 Hz divider output, synchronised)
//  run         in   1        1 = play; 0 = freeze scroll and judging (render continues)
//  clear       in   1        synchronous clear of rows, sub counter and score counters
//  note_in     in   LANES    pattern loaded into row 0 on a row advance
//  note_req    out  1        one-cycle pulse on each row advance (advance note ROM address)
//  key         in   LANES    key levels, active-high, already debounced
//  px          in   9        raster x (0..319)
//  py          in   8        raster y (0..239)
//  colour      out  3        pixel colour for (px,py), registered
//  hit         out  LANES    one-cycle pulse per lane on a successful hit
//  miss        out  LANES    one-cycle pulse per lane on a note leaving unhit
//  hit_count   out  16       saturating hit total
//  miss_count  out  16       saturating miss total
// BEHAVIOUR
//  Reset: rows=0, sub=0, key_q=0, note_req=0, hit=0, miss=0, counts=0, colour=3'b000.
//  clear (resetn=1): same as reset except key_q still samples key; clear beats tick/key.
//  Scroll (tick & run): sub<TICKS_PER_ROW-1 -> sub++. Else row advance that cycle:
//   sub<=0; row[r]<=row[r-1]; row[0]<=note_in; note_req=1 next cycle.
//   Each set bit of row[ROWS-1] shifted out -> miss[l]=1 next cycle, miss_count++ per bit.
//  Judge: key_q registers key each cycle; rise[l]=key[l]&~key_q[l]. When run & rise[l]:
//   row[ROWS-1][l]=1 -> clear that bit, hit[l]=1 next cycle, hit_count++; else no effect.
//   Keys gated while run=0 (rises discarded, no deferred judge).
//  Simultaneous rise and row advance: judge uses pre-shift row[ROWS-1]; a hit note
//   produces hit, not miss. Multiple lanes in one cycle: counts add popcount.
//  Counters saturate at 16'hFFFF, never wrap.
//  Render, 1-cycle latency (colour reflects px,py of previous cycle), priority:
//   1) lane l x-range [X0+l*(LANE_W+GAP), +LANE_W-1]:
//      py==JUDGE_Y or JUDGE_Y+1 -> 3'b000;
//      some row r with bit l set, top<=py<=top+NOTE_H, py<JUDGE_Y -> lane colour;
//      else 3'b111.
//   2) GAP-wide columns left of each lane and right of last lane -> 3'b000.
//   3) else 3'b111.
//   Lane colour by l mod 4: 0->101, 1->110, 2->011, 3->100.
//   Row top computed at full width (no 8-bit wrap); tops >= 240 never drawn.
// TESTING
//  Reset with run=1, ticks -> colour 000 then 111 off-highway, counts 0, no note_req for 4 ticks.
//  note_in=4'b0001 on 1st advance, 55 ticks, no keys -> miss=4'b0001 once after 11 advances, miss_count=1.
//  Same note, key[0] rises while bit in row 10 -> hit=4'b0001, hit_count=1, no miss at exit.
//  Key rise on advance cycle with bit in row 10 -> hit, not miss; held key -> one judge.
//  Render: row 3 lane 1 set, sub=2 -> px=145,py=68..78 colour 110; py=220 black; px=123 black.
//  Preload miss_count=FFFE, 3 misses -> FFFF; clear mid-scroll -> rows, sub, counts 0 next cycle.

Source files
------------

// File: rtl/note_highway.sv
// Falling-note playfield: scrolls a ROWS x LANES note shift register toward the
// judge line, judges key rises as hits, counts notes scrolling off as misses,
// and renders the registered playfield colour for the raster scanner.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   tick, run, clear   scroll strobe, play enable, synchronous clear
//   note_in, note_req  pattern loaded into row 0 on advance; pulse per advance
//   key                debounced key levels (active-high)
//   px, py, colour     raster coordinate in, pixel colour out (1-cycle latency)
//   hit, miss          per-lane one-cycle judge pulses
//   hit_count, miss_count  saturating totals
module note_highway #(
    parameter int LANES         = 4,
    parameter int ROWS          = 11,
    parameter int ROW_PITCH     = 20,
    parameter int TICKS_PER_ROW = 5,
    parameter int NOTE_H        = 10,
    parameter int LANE_W        = 16,
    parameter int GAP           = 2,
    parameter int X0            = 125,
    parameter int JUDGE_Y       = 220
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             run,
    input  logic             clear,
    input  logic [LANES-1:0] note_in,
    output logic             note_req,
    input  logic [LANES-1:0] key,
    input  logic [8:0]       px,
    input  logic [7:0]       py,
    output logic [2:0]       colour,
    output logic [LANES-1:0] hit,
    output logic [LANES-1:0] miss,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    localparam int STEP = ROW_PITCH / TICKS_PER_ROW;
    localparam int SW   = (TICKS_PER_ROW > 1) ? $clog2(TICKS_PER_ROW) : 1;
    localparam int PW   = $clog2(LANES + 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(TICKS_PER_ROW - 1);

    logic [LANES-1:0] rows_q [ROWS];
    logic [LANES-1:0] rows_d [ROWS];
    logic [SW-1:0]    sub_q, sub_d;
    logic [LANES-1:0] key_q;
    logic [LANES-1:0] hit_q, hit_d, miss_q, miss_d;
    logic             req_q, req_d;
    logic [15:0]      hcnt_q, hcnt_d, mcnt_q, mcnt_d;
    logic [2:0]       col_q, col_d;
    logic [LANES-1:0] rise, judge, last_left;
    logic             adv;
    int               x, y, xl, top;
    logic             on_note;

    function automatic logic [PW-1:0] popcnt(input logic [LANES-1:0] v);
        logic [PW-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + PW'(v[i]);
        return n;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] c,
                                            input logic [PW-1:0] n);
        logic [16:0] s;
        s = {1'b0, c} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [2:0] lane_col(input int l);
        case (l % 4)
            0:       return 3'b101;
            1:       return 3'b110;
            2:       return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    // Scroll and judge
    always_comb begin
        rise      = key & ~key_q;
        judge     = run ? (rise & rows_q[ROWS-1]) : '0;
        // A note judged this cycle is a hit even if it also shifts out now
        last_left = rows_q[ROWS-1] & ~judge;
        adv       = tick && run && (sub_q == SUB_LAST);
        sub_d     = sub_q;
        if (tick && run) sub_d = adv ? '0 : sub_q + SW'(1);
        for (int r = 0; r < ROWS; r++) rows_d[r] = rows_q[r];
        rows_d[ROWS-1] = last_left;
        if (adv) begin
            rows_d[0] = note_in;
            for (int r = 1; r < ROWS; r++) rows_d[r] = rows_q[r-1];
        end
        hit_d  = judge;
        miss_d = adv ? last_left : '0;
        req_d  = adv;
        hcnt_d = sat_add(hcnt_q, popcnt(hit_d));
        mcnt_d = sat_add(mcnt_q, popcnt(miss_d));
    end

    // Render
    always_comb begin
        col_d   = 3'b111;
        x       = int'(px);
        y       = int'(py);
        xl      = 0;
        top     = 0;
        on_note = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            xl = X0 + l * (LANE_W + GAP);
            if (x >= xl - GAP && x < xl) col_d = 3'b000;
            if (l == LANES - 1 && x >= xl + LANE_W &&
                x < xl + LANE_W + GAP) col_d = 3'b000;
            if (x >= xl && x < xl + LANE_W) begin
                on_note = 1'b0;
                for (int r = 0; r < ROWS; r++) begin
                    top = r * ROW_PITCH + int'(sub_q) * STEP;
                    if (rows_q[r][l] && top < 240 && y >= top &&
                        y <= top + NOTE_H && y < JUDGE_Y) on_note = 1'b1;
                end
                if (y == JUDGE_Y || y == JUDGE_Y + 1) col_d = 3'b000;
                else if (on_note)                     col_d = lane_col(l);
                else                                  col_d = 3'b111;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
            sub_q  <= '0;
            key_q  <= '0;
            hit_q  <= '0;
            miss_q <= '0;
            req_q  <= 1'b0;
            hcnt_q <= '0;
            mcnt_q <= '0;
            col_q  <= 3'b000;
        end else begin
            key_q <= key;
            if (clear) begin
                for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
                sub_q  <= '0;
                hit_q  <= '0;
                miss_q <= '0;
                req_q  <= 1'b0;
                hcnt_q <= '0;
                mcnt_q <= '0;
                col_q  <= 3'b000;
            end else begin
                for (int r = 0; r < ROWS; r++) rows_q[r] <= rows_d[r];
                sub_q  <= sub_d;
                hit_q  <= hit_d;
                miss_q <= miss_d;
                req_q  <= req_d;
                hcnt_q <= hcnt_d;
                mcnt_q <= mcnt_d;
                col_q  <= col_d;
            end
        end
    end

    assign note_req   = req_q;
    assign colour     = col_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign hit_count  = hcnt_q;
    assign miss_count = mcnt_q;

endmodule

// File: tb/tb_note_highway.sv
// Directed bench for note_highway: scroll/miss/hit sequences, render table,
// and counter saturation on an 8-lane one-tick-per-row instance.
module tb_note_highway;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        a_tick, a_run, a_clear;
    logic [3:0]  a_note_in, a_key, a_hit, a_miss;
    logic        a_note_req;
    logic [8:0]  a_px;
    logic [7:0]  a_py;
    logic [2:0]  a_colour;
    logic [15:0] a_hit_count, a_miss_count;

    logic        b_tick, b_run, b_clear;
    logic [7:0]  b_note_in, b_key, b_hit, b_miss;
    logic        b_note_req;
    logic [8:0]  b_px;
    logic [7:0]  b_py;
    logic [2:0]  b_colour;
    logic [15:0] b_hit_count, b_miss_count;

    note_highway dut_a (
        .clk(clk), .resetn(resetn), .tick(a_tick), .run(a_run),
        .clear(a_clear), .note_in(a_note_in), .note_req(a_note_req),
        .key(a_key), .px(a_px), .py(a_py), .colour(a_colour),
        .hit(a_hit), .miss(a_miss), .hit_count(a_hit_count),
        .miss_count(a_miss_count)
    );

    note_highway #(.LANES(8), .TICKS_PER_ROW(1)) dut_b (
        .clk(clk), .resetn(resetn), .tick(b_tick), .run(b_run),
        .clear(b_clear), .note_in(b_note_in), .note_req(b_note_req),
        .key(b_key), .px(b_px), .py(b_py), .colour(b_colour),
        .hit(b_hit), .miss(b_miss), .hit_count(b_hit_count),
        .miss_count(b_miss_count)
    );

    typedef struct {
        logic [8:0] px;
        logic [7:0] py;
        logic [2:0] exp;
    } rvec_t;

    rvec_t rv [16];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        a_tick  = 1'b0;
        a_clear = 1'b1;
        cyc();
        a_clear = 1'b0;
    endtask

    int nm, at, first;
    logic [3:0] mv;
    bit ok;

    initial begin
        // row 3 lane 1 set, sub=2: note spans y 68..78, lane 1 x 143..158
        rv[0]  = '{9'd145, 8'd68,  3'b110};
        rv[1]  = '{9'd145, 8'd73,  3'b110};
        rv[2]  = '{9'd145, 8'd78,  3'b110};
        rv[3]  = '{9'd145, 8'd67,  3'b111};
        rv[4]  = '{9'd145, 8'd79,  3'b111};
        rv[5]  = '{9'd145, 8'd220, 3'b000};
        rv[6]  = '{9'd145, 8'd221, 3'b000};
        rv[7]  = '{9'd145, 8'd222, 3'b111};
        rv[8]  = '{9'd123, 8'd100, 3'b000};
        rv[9]  = '{9'd124, 8'd100, 3'b000};
        rv[10] = '{9'd125, 8'd68,  3'b111};
        rv[11] = '{9'd143, 8'd68,  3'b110};
        rv[12] = '{9'd158, 8'd70,  3'b110};
        rv[13] = '{9'd159, 8'd70,  3'b000};
        rv[14] = '{9'd195, 8'd50,  3'b000};
        rv[15] = '{9'd197, 8'd50,  3'b111};

        resetn = 1'b0;
        a_tick = 0; a_run = 1; a_clear = 0; a_note_in = 0; a_key = 0;
        a_px = 0; a_py = 0;
        b_tick = 0; b_run = 1; b_clear = 0; b_note_in = 0; b_key = 0;
        b_px = 0; b_py = 0;
        repeat (2) cyc();
        chk("rst_colour", 32'(a_colour), 0);
        chk("rst_hitcnt", 32'(a_hit_count), 0);
        chk("rst_misscnt", 32'(a_miss_count), 0);
        chk("rst_req", 32'(a_note_req), 0);
        chk("rst_hit", 32'(a_hit), 0);
        chk("rst_miss", 32'(a_miss), 0);
        resetn = 1'b1;
        cyc();
        chk("off_hwy_colour", 32'(a_colour), 3'b111);

        a_tick = 1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("no_req_early", 32'(a_note_req), 0);
        end
        cyc();
        chk("req_5th", 32'(a_note_req), 1);
        a_tick = 0;
        cyc();
        chk("req_pulse", 32'(a_note_req), 0);

        // Unhit note scrolls off
        clr();
        nm = 0; at = 0; mv = 0;
        a_tick = 1;
        for (int i = 1; i <= 70; i++) begin
            a_note_in = (i <= 5) ? 4'b0001 : 4'b0000;
            cyc();
            if (a_miss != 0) begin nm++; at = i; mv = a_miss; end
        end
        a_tick = 0; a_note_in = 0;
        chk("miss_once", 32'(nm), 1);
        chk("miss_tick", 32'(at), 60);
        chk("miss_lane", 32'(mv), 4'b0001);
        chk("miss_count1", 32'(a_miss_count), 1);
        chk("miss_nohit", 32'(a_hit_count), 0);

        // Hit while in last row, with run gating first
        clr();
        a_tick = 1;
        for (int i = 1; i <= 55; i++) begin
            a_note_in = (i <= 5) ? 4'b0001 : 4'b0000;
            cyc();
        end
        a_tick = 0; a_note_in = 0;
        a_run = 0; a_key = 4'b0001;
        cyc();
        chk("gated_hit", 32'(a_hit), 0);
        a_run = 1;
        cyc();
        chk("no_defer", 32'(a_hit), 0);
        a_key = 0;
        cyc();
        a_key = 4'b0001;
        cyc();
        chk("hit_pulse", 32'(a_hit), 4'b0001);
        chk("hit_count1", 32'(a_hit_count), 1);
        cyc();
        chk("hit_once", 32'(a_hit), 0);
        a_key = 0; a_tick = 1; nm = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (a_miss != 0) nm++;
        end
        a_tick = 0;
        chk("hit_no_miss", 32'(nm), 0);
        chk("hit_misscnt", 32'(a_miss_count), 0);

        // Rise on the advance cycle, then held key through a second note
        clr();
        a_tick = 1; nm = 0;
        for (int i = 1; i <= 125; i++) begin
            a_note_in = (i <= 5 || i == 60) ? 4'b0001 : 4'b0000;
            a_key = (i >= 60) ? 4'b0001 : 4'b0000;
            cyc();
            if (i == 60) begin
                chk("adv_hit", 32'(a_hit), 4'b0001);
                chk("adv_nomiss", 32'(a_miss), 0);
            end
            if (a_miss != 0) nm++;
        end
        a_key = 0; a_note_in = 0;
        chk("held_hitcnt", 32'(a_hit_count), 1);
        chk("held_misscnt", 32'(a_miss_count), 1);
        chk("held_nmiss", 32'(nm), 1);

        // Clear mid-scroll
        a_px = 9'd130; a_py = 8'd10;
        for (int i = 1; i <= 7; i++) begin
            a_note_in = 4'hF;
            cyc();
        end
        chk("pre_clear_draw", 32'(a_colour), 3'b101);
        a_clear = 1;
        cyc();
        a_clear = 0; a_tick = 0; a_note_in = 0;
        chk("clr_hitcnt", 32'(a_hit_count), 0);
        chk("clr_misscnt", 32'(a_miss_count), 0);
        chk("clr_req", 32'(a_note_req), 0);
        chk("clr_colour", 32'(a_colour), 0);
        cyc();
        chk("clr_rows", 32'(a_colour), 3'b111);
        a_tick = 1; first = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (a_note_req && first == 0) first = i;
        end
        a_tick = 0;
        chk("clr_sub", 32'(first), 5);

        // Render table
        clr();
        a_tick = 1;
        for (int i = 1; i <= 22; i++) begin
            a_note_in = (i <= 5) ? 4'b0010 : 4'b0000;
            cyc();
        end
        a_tick = 0; a_note_in = 0;
        for (int k = 0; k < 16; k++) begin
            a_px = rv[k].px;
            a_py = rv[k].py;
            cyc();
            chk($sformatf("render%0d_%0d_%0d", k, rv[k].px, rv[k].py),
                32'(a_colour), 32'(rv[k].exp));
        end

        // Saturation: 8191*8 misses, then 6 -> FFFE, then 3 -> FFFF
        b_tick = 1;
        for (int i = 0; i < 8191; i++) begin
            b_note_in = 8'hFF;
            cyc();
        end
        b_note_in = 8'h3F;
        cyc();
        b_note_in = 8'h07;
        cyc();
        b_note_in = 8'h00;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cyc();
            if (b_miss == 8'h3F) ok = 1;
        end
        chk("sat_seen", 32'(ok), 1);
        chk("sat_fffe", 32'(b_miss_count), 16'hFFFE);
        cyc();
        chk("sat_miss7", 32'(b_miss), 8'h07);
        chk("sat_ffff", 32'(b_miss_count), 16'hFFFF);
        repeat (3) cyc();
        chk("sat_hold", 32'(b_miss_count), 16'hFFFF);
        b_tick = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
